// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands in a small FIFO and sequences them
// one at a time through an external ALU. The block drives the ALU operand and
// select lines, waits out the ALU latency, and hands each result back over a
// valid/ready interface in FIFO order.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  input  logic                     cmd_chain,
  output logic [2:0]               alu_in_sel,
  output logic [7:0]               alu_num1,
  output logic [7:0]               alu_num2,
  output logic [6:0]               alu_out_sel,
  input  logic [7:0]               alu_result,
  input  logic                     alu_ovf,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output logic                     res_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(ALU_LAT + 1) + 1;
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(ALU_LAT);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_CLEAR   = 3'b001;
  localparam logic [2:0] OP_RSVD     = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
  } cmd_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               rsvd_q, rsvd_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [2:0]         in_sel_q, in_sel_d;
  logic [7:0]         num1_q, num1_d;
  logic [7:0]         num2_q, num2_d;
  logic [6:0]         out_sel_q, out_sel_d;
  logic               res_valid_q, res_valid_d;
  logic [7:0]         res_data_q, res_data_d;
  logic               res_err_q, res_err_d;

  cmd_t               fifo_mem [DEPTH];
  cmd_t               head;
  logic               push;
  logic               pop;

  // Acceptance depends only on registered occupancy, never on a same-cycle pop.
  assign cmd_ready = (count_q < FULL_COUNT) && rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign head      = fifo_mem[rd_ptr_q];

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // FIFO storage write on an accepted command.
  // NOTE: the storage array is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain};
  end

  // State register plus every registered output, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    if (!rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      rsvd_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_sel_q    <= SEL_CLEAR;
      num1_q      <= 8'h00;
      num2_q      <= 8'h00;
      out_sel_q   <= 7'b0000000;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rsvd_q      <= rsvd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_sel_q    <= in_sel_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      out_sel_q   <= out_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  // Next-state logic. WAIT spans the ALU capture edge plus ALU_LAT cycles so
  // the result sampled on leaving WAIT is the settled one.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    rsvd_d     = rsvd_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_ISSUE;
          rsvd_d  = (head.op == OP_RSVD);
        end
      end
      S_ISSUE: state_d = rsvd_q ? S_OUT : S_WAIT;
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_OUT;
        else                         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: values each registered output takes on the coming edge.
  // The accumulator is held (persist) everywhere except a non-chained issue.
  always_comb begin
    in_sel_d    = SEL_PERSIST;
    num1_d      = num1_q;
    num2_d      = num2_q;
    out_sel_d   = out_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (pop && head.op != OP_RSVD) begin
          num1_d    = head.a;
          num2_d    = head.b;
          out_sel_d = 7'b1 << head.op;
          in_sel_d  = head.chain ? SEL_PERSIST : SEL_LOAD;
        end
      end
      S_ISSUE: begin
        if (rsvd_q) begin
          res_valid_d = 1'b1;
          res_data_d  = 8'h00;
          res_err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          res_valid_d = 1'b1;
          res_data_d  = alu_result;
          res_err_d   = alu_ovf;
        end
      end
      S_OUT: begin
        if (res_ready) res_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign alu_in_sel  = in_sel_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_out_sel = out_sel_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;
  assign busy        = (state_q != S_IDLE);
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a behavioural ALU with an accumulator and
// one cycle of result latency, a table of single-command vectors, and directed
// sequences for chaining, FIFO back-pressure and mid-operation reset.
module tb_alu_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_chain;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1;
  logic [7:0] alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_result = 8'h00;
  logic       alu_ovf    = 1'b0;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .busy(busy), .fifo_count(fifo_count)
  );

  // Behavioural ALU: result = {ovf, data}; ovf is carry, borrow or MUL high byte.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [6:0] sel);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (sel)
      7'b0000001: return {1'b0, a & b};
      7'b0000010: return {1'b0, a | b};
      7'b0000100: return {1'b0, ~a};
      7'b0001000: return {1'b0, a ^ b};
      7'b0010000: return {1'b0, a} + {1'b0, b};
      7'b0100000: return {a < b, a - b};
      7'b1000000: return {|p[15:8], p[7:0]};
      default:    return 9'd0;
    endcase
  endfunction

  // The ALU captures on a load or whenever the operands/select change, keeps the
  // result as its accumulator, and presents it one edge later.
  logic [7:0] acc = 8'h00;
  logic       acc_ovf = 1'b0;
  logic [7:0] p_n1 = 8'h00;
  logic [7:0] p_n2 = 8'h00;
  logic [6:0] p_sel = 7'h00;
  always @(posedge clk) begin
    p_n1  <= alu_num1;
    p_n2  <= alu_num2;
    p_sel <= alu_out_sel;
    if (alu_in_sel == 3'b001) begin
      acc     <= 8'h00;
      acc_ovf <= 1'b0;
    end else if (alu_in_sel == 3'b010 || {alu_num1, alu_num2, alu_out_sel} != {p_n1, p_n2, p_sel}) begin
      {acc_ovf, acc} <= alu_f((alu_in_sel == 3'b010) ? alu_num1 : acc, alu_num2, alu_out_sel);
    end
    alu_result <= acc;
    alu_ovf    <= acc_ovf;
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input vec_t v, input logic chain);
    cmd_op    = v.op;
    cmd_a     = v.a;
    cmd_b     = v.b;
    cmd_chain = chain;
    cmd_valid = 1'b1;
  endtask

  // One command from an empty idle block, with result latency and issue checks.
  task automatic run_vec(input int i);
    vec_t       v;
    logic [6:0] oh;
    logic [6:0] sel_before;
    logic       saw_load;
    logic       sel_moved;
    int         cyc;
    v = vecs[i];
    oh = 7'b1 << v.op;
    sel_before = alu_out_sel;
    saw_load = 1'b0;
    sel_moved = 1'b0;
    res_ready = 1'b1;
    drive_cmd(v, 1'b0);
    check($sformatf("v%0d_cmd_ready", i), cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      tick();
      cyc++;
      if (alu_in_sel == 3'b010) saw_load = 1'b1;
      if (alu_out_sel != sel_before) sel_moved = 1'b1;
      if (cyc == 1 && v.op != 3'd7)
        check($sformatf("v%0d_issue", i), {alu_in_sel, alu_out_sel, alu_num1, alu_num2},
              {3'b010, oh, v.a, v.b});
      if (cyc == 2 && v.op != 3'd7)
        check($sformatf("v%0d_wait_in_sel", i), alu_in_sel, 3'b100);
    end
    check($sformatf("v%0d_latency", i), cyc, (v.op == 3'd7) ? 2 : ALU_LAT + 3);
    check($sformatf("v%0d_data", i), res_data, v.exp_data);
    check($sformatf("v%0d_err", i), res_err, v.exp_err);
    if (v.op == 3'd7) begin
      check($sformatf("v%0d_rsvd_no_load", i), saw_load, 0);
      check($sformatf("v%0d_rsvd_sel_held", i), sel_moved, 0);
    end
    tick();
    check($sformatf("v%0d_release", i), {res_valid, busy}, 2'b00);
  endtask

  // Waits for the next result (bounded), compares it, then completes the handshake.
  task automatic take_result(input string name, input logic [7:0] exp_data, input logic exp_err);
    int cyc;
    cyc = 0;
    while (!res_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({name, "_arrived"}, res_valid, 1);
    check({name, "_data"}, res_data, exp_data);
    check({name, "_err"}, res_err, exp_err);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t chain_add;
    vec_t chain_sub;
    int   n_acc;
    logic seen_sub;
    logic any_valid;
    int   cyc;

    vecs[0]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1]  = '{3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    vecs[2]  = '{3'd2, 8'h5A, 8'h00, 8'hA5, 1'b0};
    vecs[3]  = '{3'd3, 8'hFF, 8'h0F, 8'hF0, 1'b0};
    vecs[4]  = '{3'd4, 8'h12, 8'h34, 8'h46, 1'b0};
    vecs[5]  = '{3'd4, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[6]  = '{3'd5, 8'h10, 8'h01, 8'h0F, 1'b0};
    vecs[7]  = '{3'd5, 8'h01, 8'h02, 8'hFF, 1'b1};
    vecs[8]  = '{3'd6, 8'h20, 8'h10, 8'h00, 1'b1};
    vecs[9]  = '{3'd6, 8'h0F, 8'h11, 8'hFF, 1'b0};
    vecs[10] = '{3'd7, 8'hFF, 8'h00, 8'h00, 1'b1};

    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_a = 8'h00;
    cmd_b = 8'h00;
    cmd_chain = 1'b0;
    res_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_alu_outs", {alu_in_sel, alu_out_sel, alu_num1, alu_num2}, {3'b001, 7'h00, 8'h00, 8'h00});
    check("rst_result", {res_valid, res_data, res_err}, 10'h000);
    check("rst_fifo_busy", {busy, fifo_count}, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b1;
    tick();
    check("post_rst_in_sel", alu_in_sel, 3'b100);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Table-driven single commands.
    for (int i = 0; i < 11; i++) run_vec(i);

    // Chained ADD then SUB using the accumulator.
    chain_add = '{3'd4, 8'h05, 8'h03, 8'h08, 1'b0};
    chain_sub = '{3'd5, 8'h00, 8'h02, 8'h06, 1'b0};
    res_ready = 1'b1;
    drive_cmd(chain_add, 1'b0);
    tick();
    drive_cmd(chain_sub, 1'b1);
    tick();
    cmd_valid = 1'b0;
    seen_sub = 1'b0;
    for (int r = 0; r < 2; r++) begin
      cyc = 0;
      while (!res_valid && cyc < 40) begin
        tick();
        cyc++;
        if (alu_out_sel == 7'b0100000 && !seen_sub) begin
          seen_sub = 1'b1;
          check("chain_issue_in_sel", alu_in_sel, 3'b100);
        end
      end
      check($sformatf("chain_r%0d_data", r), res_data, (r == 0) ? 8'h08 : 8'h06);
      check($sformatf("chain_r%0d_err", r), res_err, 0);
      tick();
    end
    check("chain_sub_issued", seen_sub, 1);

    // Back-pressure: six back-to-back pushes with results stalled.
    res_ready = 1'b0;
    n_acc = 0;
    for (int j = 0; j < 6; j++) begin
      drive_cmd(vecs[(j < 5) ? j : 6], 1'b0);
      if (cmd_ready) n_acc++;
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_accepted", n_acc, 5);
    check("bp_fifo_count", fifo_count, 4);
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_out_waiting", res_valid, 1);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++)
      take_result($sformatf("bp_r%0d", k), vecs[k].exp_data, vecs[k].exp_err);
    check("bp_drained", {busy, fifo_count}, 0);

    // Reset during WAIT with two commands queued.
    drive_cmd(vecs[4], 1'b0);
    tick();
    drive_cmd(vecs[6], 1'b0);
    tick();
    drive_cmd(vecs[0], 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("mid_rst_pre", {busy, fifo_count}, {1'b1, 3'd2});
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_state", {busy, fifo_count, res_valid}, 0);
    check("mid_rst_in_sel", alu_in_sel, 3'b001);
    tick();
    check("mid_rst_release_in_sel", alu_in_sel, 3'b100);
    any_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (res_valid) any_valid = 1'b1;
      tick();
    end
    check("mid_rst_no_result", any_valid, 0);

    // Normal operation resumes after the reset.
    run_vec(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
